// File: rtl/tt_pad_ring_if.sv
// Pad-side and core-side signal bundle of the Tiny Tapeout pad ring.
// The environment (board pins plus project core) uses master; the ring itself uses slave.
interface tt_pad_ring_if #(
   parameter int N_UI  = 8,
   parameter int N_UIO = 8
);
   logic [N_UI-1:0]  pad_ui;
   logic [N_UIO-1:0] pad_uio_in;
   logic [N_UIO-1:0] pad_uio_out;
   logic [N_UIO-1:0] pad_uio_oe;
   logic [N_UI-1:0]  ui_in;
   logic [N_UIO-1:0] uio_in;
   logic [N_UIO-1:0] core_uio_out;
   logic [N_UIO-1:0] core_uio_oe;
   logic             core_rst_n;
   logic [N_UIO-1:0] turn_busy;

   modport master (
      output pad_ui, pad_uio_in, core_uio_out, core_uio_oe,
      input  pad_uio_out, pad_uio_oe, ui_in, uio_in, core_rst_n, turn_busy
   );

   modport slave (
      input  pad_ui, pad_uio_in, core_uio_out, core_uio_oe,
      output pad_uio_out, pad_uio_oe, ui_in, uio_in, core_rst_n, turn_busy
   );
endinterface

// File: rtl/tt_pad_ring.sv
// Pad ring for a Tiny Tapeout core: input synchronisers, stretched core reset and
// per-pin drive turnaround so a uio pad is Z for TURNAROUND cycles on each direction change.
module tt_pad_ring #(
   parameter int N_UI        = 8,
   parameter int N_UIO       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TURNAROUND  = 1,
   parameter int RST_HOLD    = 4
) (
   input logic         clk,
   input logic         rst,
   tt_pad_ring_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IN   = 2'd0,
      ST_DRV  = 2'd1,
      ST_TURN = 2'd2
   } pin_state_e;

   localparam logic [2:0] TURN_LOAD = 3'(TURNAROUND);
   localparam logic [7:0] HOLD_LOAD = 8'(RST_HOLD);

   logic [N_UI-1:0]  ui_sync_r  [SYNC_STAGES];
   logic [N_UIO-1:0] uio_sync_r [SYNC_STAGES];
   logic [7:0]       hold_cnt_r;
   logic             core_rst_n_r;

   pin_state_e       state_r     [N_UIO];
   pin_state_e       state_nxt_s [N_UIO];
   logic [2:0]       cnt_r       [N_UIO];
   logic [2:0]       cnt_nxt_s   [N_UIO];
   logic [N_UIO-1:0] tgt_r;
   logic [N_UIO-1:0] tgt_nxt_s;
   logic [N_UIO-1:0] oe_r;
   logic [N_UIO-1:0] busy_r;
   logic [N_UIO-1:0] out_r;

   // Plain shift-register synchronisers; uio pads are sampled whatever their direction.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            ui_sync_r[i]  <= {N_UI{1'b0}};
            uio_sync_r[i] <= {N_UIO{1'b0}};
         end
      end else begin
         ui_sync_r[0]  <= bus.pad_ui;
         uio_sync_r[0] <= bus.pad_uio_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            ui_sync_r[i]  <= ui_sync_r[i-1];
            uio_sync_r[i] <= uio_sync_r[i-1];
         end
      end
   end

   // Core reset stretch: release lands RST_HOLD edges after the first edge that sees rst low.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt_r   <= HOLD_LOAD;
         core_rst_n_r <= 1'b0;
      end else begin
         if (hold_cnt_r != 8'd0) begin
            hold_cnt_r <= hold_cnt_r - 8'd1;
         end else begin
            hold_cnt_r <= hold_cnt_r;
         end
         core_rst_n_r <= (hold_cnt_r == 8'd0);
      end
   end

   // Per-pin direction FSM; any request change while in TURN restarts the dead time.
   always_comb begin
      for (int p = 0; p < N_UIO; p++) begin
         state_nxt_s[p] = state_r[p];
         cnt_nxt_s[p]   = cnt_r[p];
         tgt_nxt_s[p]   = tgt_r[p];
         if (!core_rst_n_r) begin
            state_nxt_s[p] = ST_IN;
            cnt_nxt_s[p]   = 3'd0;
            tgt_nxt_s[p]   = 1'b0;
         end else begin
            case (state_r[p])
               ST_IN: begin
                  if (bus.core_uio_oe[p]) begin
                     if (TURNAROUND == 0) begin
                        state_nxt_s[p] = ST_DRV;
                     end else begin
                        state_nxt_s[p] = ST_TURN;
                        cnt_nxt_s[p]   = TURN_LOAD;
                        tgt_nxt_s[p]   = 1'b1;
                     end
                  end else begin
                     state_nxt_s[p] = ST_IN;
                  end
               end
               ST_DRV: begin
                  if (!bus.core_uio_oe[p]) begin
                     if (TURNAROUND == 0) begin
                        state_nxt_s[p] = ST_IN;
                     end else begin
                        state_nxt_s[p] = ST_TURN;
                        cnt_nxt_s[p]   = TURN_LOAD;
                        tgt_nxt_s[p]   = 1'b0;
                     end
                  end else begin
                     state_nxt_s[p] = ST_DRV;
                  end
               end
               ST_TURN: begin
                  if (bus.core_uio_oe[p] != tgt_r[p]) begin
                     cnt_nxt_s[p] = TURN_LOAD;
                     tgt_nxt_s[p] = bus.core_uio_oe[p];
                  end else if (cnt_r[p] <= 3'd1) begin
                     state_nxt_s[p] = bus.core_uio_oe[p] ? ST_DRV : ST_IN;
                     cnt_nxt_s[p]   = 3'd0;
                  end else begin
                     cnt_nxt_s[p] = cnt_r[p] - 3'd1;
                  end
               end
               default: begin
                  state_nxt_s[p] = ST_IN;
                  cnt_nxt_s[p]   = 3'd0;
                  tgt_nxt_s[p]   = 1'b0;
               end
            endcase
         end
      end
   end

   // Pin state plus pad outputs, decoded from next state so they leave flops directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int p = 0; p < N_UIO; p++) begin
            state_r[p] <= ST_IN;
            cnt_r[p]   <= 3'd0;
         end
         tgt_r  <= {N_UIO{1'b0}};
         oe_r   <= {N_UIO{1'b0}};
         busy_r <= {N_UIO{1'b0}};
         out_r  <= {N_UIO{1'b0}};
      end else begin
         for (int p = 0; p < N_UIO; p++) begin
            state_r[p] <= state_nxt_s[p];
            cnt_r[p]   <= cnt_nxt_s[p];
            oe_r[p]    <= (state_nxt_s[p] == ST_DRV);
            busy_r[p]  <= (state_nxt_s[p] == ST_TURN);
         end
         tgt_r <= tgt_nxt_s;
         out_r <= bus.core_uio_out;
      end
   end

   assign bus.ui_in       = ui_sync_r[SYNC_STAGES-1];
   assign bus.uio_in      = uio_sync_r[SYNC_STAGES-1];
   assign bus.core_rst_n  = core_rst_n_r;
   assign bus.pad_uio_out = out_r;
   assign bus.pad_uio_oe  = oe_r;
   assign bus.turn_busy   = busy_r;

endmodule
